// File: rtl/pll_mon_pkg.sv
// Shared types and defaults for the PLL lock monitor and related reset logic.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } pll_state_e;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_CNT_W         = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for asynchronous level inputs.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies PLL lock over a stable window before releasing the system reset,
// and records lock-loss events seen while running.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             locked,
  input  logic             lost_clr,
  output logic             sys_resetn,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lost_cnt,
  output logic             lost_sticky
);

  localparam int unsigned      STB_W    = cnt_width(STABLE_CYCLES);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             lk_s;
  pll_state_e       state_q, state_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic             sys_resetn_q, sys_resetn_d;
  logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
  logic             lost_sticky_q, lost_sticky_d;
  logic [CNT_W-1:0] lost_base;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (locked),
    .q     (lk_s)
  );

  // Next-state, qualification counter and loss bookkeeping.
  always_comb begin
    state_d       = state_q;
    stb_cnt_d     = stb_cnt_q;
    sys_resetn_d  = 1'b0;
    lost_base     = lost_clr ? '0 : lost_cnt_q;
    lost_cnt_d    = lost_base;
    lost_sticky_d = lost_clr ? 1'b0 : lost_sticky_q;

    case (state_q)
      WAIT_LOCK: begin
        stb_cnt_d = '0;
        if (lk_s) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_d   = WAIT_LOCK;
          stb_cnt_d = '0;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d      = RUN;
          stb_cnt_d    = '0;
          sys_resetn_d = 1'b1;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (lk_s) begin
          sys_resetn_d = 1'b1;
        end else begin
          // A loss event takes priority over a coincident clear.
          state_d       = WAIT_LOCK;
          lost_sticky_d = 1'b1;
          lost_cnt_d    = (lost_base == CNT_MAX) ? lost_base : lost_base + 1'b1;
        end
      end
      default: begin
        state_d   = WAIT_LOCK;
        stb_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= WAIT_LOCK;
      stb_cnt_q     <= '0;
      sys_resetn_q  <= 1'b0;
      lost_cnt_q    <= '0;
      lost_sticky_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stb_cnt_q     <= stb_cnt_d;
      sys_resetn_q  <= sys_resetn_d;
      lost_cnt_q    <= lost_cnt_d;
      lost_sticky_q <= lost_sticky_d;
    end
  end

  assign sys_resetn  = sys_resetn_q;
  assign state       = state_q;
  assign lost_cnt    = lost_cnt_q;
  assign lost_sticky = lost_sticky_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench: two monitor instances (short/long qualification windows) share stimulus.
module tb_pll_lock_monitor;

  logic       clk;
  logic       resetn;
  logic       locked;
  logic       lost_clr;

  logic       a_sys_resetn, b_sys_resetn;
  logic [1:0] a_state, b_state;
  logic [1:0] a_lost_cnt;
  logic [7:0] b_lost_cnt;
  logic       a_lost_sticky, b_lost_sticky;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string tag;
    int    dut;
    int    sysr;
    int    st;
    int    cnt;
    int    sticky;
  } exp_t;

  exp_t sb[$];

  // Instance A: 4-cycle window, 2-bit saturating loss counter.
  pll_lock_monitor #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .CNT_W         (2)
  ) u_dut_a (
    .clk         (clk),
    .resetn      (resetn),
    .locked      (locked),
    .lost_clr    (lost_clr),
    .sys_resetn  (a_sys_resetn),
    .state       (a_state),
    .lost_cnt    (a_lost_cnt),
    .lost_sticky (a_lost_sticky)
  );

  // Instance B: 8-cycle window, 8-bit loss counter.
  pll_lock_monitor #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .CNT_W         (8)
  ) u_dut_b (
    .clk         (clk),
    .resetn      (resetn),
    .locked      (locked),
    .lost_clr    (lost_clr),
    .sys_resetn  (b_sys_resetn),
    .state       (b_state),
    .lost_cnt    (b_lost_cnt),
    .lost_sticky (b_lost_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int dut, input int sysr,
                      input int st, input int cnt, input int sticky);
    exp_t e;
    e.tag = tag; e.dut = dut; e.sysr = sysr; e.st = st; e.cnt = cnt; e.sticky = sticky;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
    end
  endtask

  // Pop every queued expectation and compare against the current DUT outputs.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        cmp(e.tag, "a_sys_resetn", 32'(a_sys_resetn), 32'(e.sysr));
        cmp(e.tag, "a_state", 32'(a_state), 32'(e.st));
        cmp(e.tag, "a_lost_cnt", 32'(a_lost_cnt), 32'(e.cnt));
        cmp(e.tag, "a_lost_sticky", 32'(a_lost_sticky), 32'(e.sticky));
      end else begin
        cmp(e.tag, "b_sys_resetn", 32'(b_sys_resetn), 32'(e.sysr));
        cmp(e.tag, "b_state", 32'(b_state), 32'(e.st));
        cmp(e.tag, "b_lost_cnt", 32'(b_lost_cnt), 32'(e.cnt));
        cmp(e.tag, "b_lost_sticky", 32'(b_lost_sticky), 32'(e.sticky));
      end
    end
  endtask

  initial begin
    resetn   = 1'b0;
    locked   = 1'b0;
    lost_clr = 1'b0;
    #2;
    push("reset", 0, 0, 0, 0, 0);
    push("reset", 1, 0, 0, 0, 0);
    drain();
    tick(2);
    resetn = 1'b1;
    tick(2);

    // Basic release: A rises on edge 7, B on edge 11.
    locked = 1'b1;
    tick(2);  push("rel_e2", 0, 0, 0, 0, 0); drain();
    tick(1);  push("rel_e3", 0, 0, 1, 0, 0); push("rel_e3", 1, 0, 1, 0, 0); drain();
    tick(3);  push("rel_e6", 0, 0, 1, 0, 0); drain();
    tick(1);  push("rel_e7", 0, 1, 2, 0, 0); push("rel_e7", 1, 0, 1, 0, 0); drain();
    tick(3);  push("rel_e10", 1, 0, 1, 0, 0); drain();
    tick(1);  push("rel_e11", 1, 1, 2, 0, 0); push("rel_e11", 0, 1, 2, 0, 0); drain();

    // Lock loss from RUN: reset drops on edge 3.
    locked = 1'b0;
    tick(2);  push("loss_e2", 0, 1, 2, 0, 0); drain();
    tick(1);  push("loss_e3", 0, 0, 0, 1, 1); push("loss_e3", 1, 0, 0, 1, 1); drain();
    locked = 1'b1;
    tick(6);  push("relock_e6", 0, 0, 1, 1, 1); drain();
    tick(1);  push("relock_e7", 0, 1, 2, 1, 1); drain();
    tick(3);  push("relock_e10", 1, 0, 1, 1, 1); drain();
    tick(1);  push("relock_e11", 1, 1, 2, 1, 1); drain();

    // Saturation: A's 2-bit counter sticks at 3, B keeps counting.
    for (int k = 2; k <= 5; k++) begin
      locked = 1'b0;
      tick(3);
      push($sformatf("sat_loss%0d", k), 0, 0, 0, (k > 3) ? 3 : k, 1);
      push($sformatf("sat_loss%0d", k), 1, 0, 0, k, 1);
      drain();
      locked = 1'b1;
      tick(11);
      push($sformatf("sat_run%0d", k), 0, 1, 2, (k > 3) ? 3 : k, 1);
      push($sformatf("sat_run%0d", k), 1, 1, 2, k, 1);
      drain();
    end

    // Clear coinciding with a loss event, then a clear on its own.
    locked = 1'b0;
    tick(2);
    lost_clr = 1'b1;
    tick(1);
    lost_clr = 1'b0;
    push("clr_collide", 0, 0, 0, 1, 1); push("clr_collide", 1, 0, 0, 1, 1); drain();
    lost_clr = 1'b1;
    tick(1);
    lost_clr = 1'b0;
    push("clr_alone", 0, 0, 0, 0, 0); push("clr_alone", 1, 0, 0, 0, 0); drain();

    // Glitch during qualification: B restarts; A just reaches RUN and loses lock.
    locked = 1'b1;
    tick(5);  push("gl_h5", 0, 0, 1, 0, 0); push("gl_h5", 1, 0, 1, 0, 0); drain();
    locked = 1'b0;
    tick(2);  push("gl_i2", 0, 1, 2, 0, 0); push("gl_i2", 1, 0, 1, 0, 0); drain();
    tick(1);  push("gl_i3", 0, 0, 0, 1, 1); push("gl_i3", 1, 0, 0, 0, 0); drain();
    locked = 1'b1;
    tick(10); push("gl_j10", 1, 0, 1, 0, 0); push("gl_j10", 0, 1, 2, 1, 1); drain();
    tick(1);  push("gl_j11", 1, 1, 2, 0, 0); drain();

    // Async reset between edges, then full requalification.
    #3;
    resetn = 1'b0;
    #1;
    push("async_rst", 0, 0, 0, 0, 0); push("async_rst", 1, 0, 0, 0, 0); drain();
    tick(1);
    resetn = 1'b1;
    tick(6);  push("rq_e6", 0, 0, 1, 0, 0); drain();
    tick(1);  push("rq_e7", 0, 1, 2, 0, 0); drain();
    tick(3);  push("rq_e10", 1, 0, 1, 0, 0); drain();
    tick(1);  push("rq_e11", 1, 1, 2, 0, 0); drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
Name: pll_lock_monitor

Overview:
- Consumes the asynchronous `locked` output of the on-chip PLL wrapper.
- Runs in the PLL output clock domain and produces the synchronous system reset `sys_resetn` for the SoC.
- Releases reset only after lock has been continuously stable for a programmable number of cycles.
- Re-asserts reset immediately on lock loss and keeps a saturating lock-loss counter and a sticky flag for firmware and debug.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `locked`; legal range ≥2.
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before reset release; legal range ≥1.
- CNT_W, 8, width of the lock-loss event counter.

Ports:
- clk  in  1  PLL output clock; the only clock in the block.
- resetn  in  1  asynchronous active-low reset; assertion is async, deassertion must be synchronous to clk at the SoC top.
- locked  in  1  PLL lock indicator, asynchronous to clk.
- lost_clr  in  1  synchronous single-cycle pulse; clears `lost_cnt` and `lost_sticky`.
- sys_resetn  out  1  registered active-low system reset.
- state  out  2  FSM state: 0=WAIT_LOCK, 1=STABLE, 2=RUN; 3 is unused.
- lost_cnt  out  CNT_W  count of lock losses seen while in RUN; saturates at all-ones.
- lost_sticky  out  1  set on any lock loss from RUN.

Behaviour:
- Reset (resetn=0, asynchronous):
  - synchronizer flops = 0, state = WAIT_LOCK, stable counter = 0.
  - sys_resetn = 0, lost_cnt = 0, lost_sticky = 0.
- Synchronizer:
  - `locked` passes through SYNC_STAGES flops to give lk_s.
  - No logic other than the chain reads raw `locked`.
- WAIT_LOCK:
  - stable counter held at 0; sys_resetn = 0.
  - lk_s=1 → STABLE next edge.
- STABLE:
  - lk_s=0 → WAIT_LOCK next edge, counter cleared, no loss event.
  - lk_s=1 and counter ≠ STABLE_CYCLES-1 → counter += 1.
  - lk_s=1 and counter = STABLE_CYCLES-1 → RUN next edge; sys_resetn goes 1 on that same edge.
  - Counter width is clog2(STABLE_CYCLES), minimum 1.
- RUN:
  - sys_resetn = 1 while lk_s=1.
  - lk_s=0 → on the next edge: state = WAIT_LOCK, sys_resetn = 0, lost_sticky = 1, and lost_cnt += 1 unless already all-ones.
- Latency:
  - Counting the first edge that samples locked=1 as edge 1, sys_resetn rises on edge SYNC_STAGES+STABLE_CYCLES+1, provided locked stays high.
  - With defaults, sys_resetn rises on edge 1027.
- Lock-drop latency: sys_resetn falls on edge SYNC_STAGES+1 after the first edge sampling locked=0.
- Glitches:
  - A locked pulse shorter than the synchronizer resolution may be missed. This is acceptable.
  - Any lk_s=0 cycle during STABLE restarts qualification from zero.
- lost_clr:
  - Clears lost_cnt and lost_sticky on the next edge.
  - If a loss event occurs on the same edge, the event wins: lost_cnt = 1, lost_sticky = 1.
- sys_resetn is driven directly from a flop. It is never combinational from `locked` or lk_s.
- Clock stop: if the PLL clock stops on lock loss, sys_resetn holds its last value. The SoC top ORs in resetn for that case; that logic is outside this block.
- Unreachable state 3 → WAIT_LOCK next edge, with sys_resetn = 0.

Decomposition:
- Shared package `pll_mon_pkg`:
  - state enum: WAIT_LOCK=2'd0, STABLE=2'd1, RUN=2'd2.
  - default constants for SYNC_STAGES and STABLE_CYCLES.
- One natural sub-module: `sync_ff`, a parameterized N-stage single-bit synchronizer with async active-low reset, reused by other async-input blocks.
- FSM, stable counter and loss counter stay in pll_lock_monitor.

Test Plan:
- Basic release: STABLE_CYCLES=4, SYNC_STAGES=2; resetn released, locked held at 1 → state passes WAIT_LOCK→STABLE→RUN; sys_resetn rises on edge 7 after the first sampling edge; lost_cnt=0.
- Mid-qualification glitch: STABLE_CYCLES=8; locked=1, dropped to 0 for 3 cycles after 5 cycles, then 1 again → state returns to WAIT_LOCK; lost_cnt stays 0; sys_resetn rises 11 edges after the re-rise.
- Lock loss in RUN: from RUN, locked→0 → sys_resetn=0 on edge 3; lost_cnt=1; lost_sticky=1; state=WAIT_LOCK; re-lock gives a full requalification.
- Saturation: CNT_W=2; five lock-loss cycles from RUN → lost_cnt sequence 1,2,3,3,3.
- Clear collision: lost_clr pulsed on the same edge as a loss event → lost_cnt=1, lost_sticky=1. lost_clr pulsed alone → both 0 on the next edge.
- Async reset mid-operation: resetn asserted in RUN between clk edges → sys_resetn=0, state=0, lost_cnt=0 immediately with no clock edge; after release with locked=1, full requalification latency applies.
